// File: rtl/pmem_write_buffer.sv
// pmem_write_buffer: line-granular FIFO write buffer between the victim cache and physical memory (WB_COALESCE_EN merges same-tag writes in place).
// Latency: a write accept or read hit responds the cycle after IDLE sees it; a read miss responds the cycle after pmem_resp.
// Backpressure: requests are level-held and wait out any drain or memory read in flight; a write to a full buffer waits through one drain.
module pmem_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         read,
    input  logic         write,
    input  logic [15:0]  address,
    input  logic [127:0] wdata,
    output logic         resp,
    output logic [127:0] rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RESP, PMEM_READ, DRAIN} state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [11:0]   r_tag  [DEPTH];
    logic [127:0]  r_line [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [127:0]  r_rdata;
    logic [11:0]   r_rd_tag;

    logic [11:0]   w_req_tag;
    logic          w_hit;
    logic [AW-1:0] w_hit_idx;
    logic          w_full;
    logic          w_coal_hit;
    logic          w_push;
    logic          w_coal;
    logic          w_pop;
    logic          w_ld_hit;
    logic          w_ld_mem;
    logic          w_ld_tag;
    logic          w_unused_addr;

    // The low nibble only selects a word inside the line; lines are moved whole.
    assign w_unused_addr = ^address[3:0];
    assign w_req_tag     = address[15:4];
    assign w_full        = (r_count == CW'(DEPTH));

`ifdef WB_COALESCE_EN
    assign w_coal_hit = w_hit;
`else
    assign w_coal_hit = 1'b0;
`endif

    // Tag search from oldest to youngest so the youngest valid match wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && (r_tag[r_head + AW'(i)] == w_req_tag)) begin
                w_hit     = 1'b1;
                w_hit_idx = r_head + AW'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, datapath enables, and handshake outputs decoded from state.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_coal      = 1'b0;
        w_pop       = 1'b0;
        w_ld_hit    = 1'b0;
        w_ld_mem    = 1'b0;
        w_ld_tag    = 1'b0;
        resp        = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        case (r_state)
            IDLE: begin
                if (read && w_hit) begin
                    w_ld_hit    = 1'b1;
                    w_state_nxt = RESP;
                end else if (write && !read && (w_coal_hit || !w_full)) begin
                    w_push      = !w_coal_hit;
                    w_coal      = w_coal_hit;
                    w_state_nxt = RESP;
                end else if (read) begin
                    w_ld_tag    = 1'b1;
                    w_state_nxt = PMEM_READ;
                end else if (write) begin
                    // Full: free one slot, then the held write is accepted.
                    w_state_nxt = DRAIN;
                end else if (r_count != '0) begin
                    w_state_nxt = DRAIN;
                end
            end
            RESP: begin
                resp        = 1'b1;
                w_state_nxt = IDLE;
            end
            PMEM_READ: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    w_ld_mem    = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            DRAIN: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    w_pop       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Queue pointers and occupancy; reset discards every buffered line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_push) begin
            r_tail  <= r_tail + AW'(1);
            r_count <= r_count + CW'(1);
        end else if (w_pop) begin
            r_head  <= r_head + AW'(1);
            r_count <= r_count - CW'(1);
        end
    end

    // Line storage: append at tail on allocate, overwrite youngest match on coalesce.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag[r_tail]  <= w_req_tag;
            r_line[r_tail] <= wdata;
        end
        if (w_coal) begin
            r_line[w_hit_idx] <= wdata;
        end
    end

    // Read return data and the latched miss tag that drives the memory read address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rd_tag <= '0;
        end else begin
            if (w_ld_hit) begin
                r_rdata <= r_line[w_hit_idx];
            end else if (w_ld_mem) begin
                r_rdata <= pmem_rdata;
            end
            if (w_ld_tag) begin
                r_rd_tag <= w_req_tag;
            end
        end
    end

    assign rdata        = r_rdata;
    assign pmem_address = (r_state == DRAIN) ? {r_tag[r_head], 4'b0000} : {r_rd_tag, 4'b0000};
    assign pmem_wdata   = r_line[r_head];

endmodule
